// File: rtl/regfile_sel32_if.sv
// regfile_sel32 bus: decoder write-select plus two read ports.
// Driver side uses master, register bank uses slave.
interface regfile_sel32_if #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
);
  logic [31:0]          wr_sel;
  logic [WIDTH-1:0]     wr_data_lo;
  logic [WIDTH-1:0]     wr_data_hi;
  logic [4:0]           rd_addr_a;
  logic [4:0]           rd_addr_b;
  logic [WIDTH-1:0]     rd_data_a;
  logic [WIDTH-1:0]     rd_data_b;
  logic                 wr_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport master (
    output wr_sel, wr_data_lo, wr_data_hi,
    output rd_addr_a, rd_addr_b,
    input  rd_data_a, rd_data_b,
    input  wr_err, err_count
  );

  modport slave (
    input  wr_sel, wr_data_lo, wr_data_hi,
    input  rd_addr_a, rd_addr_b,
    output rd_data_a, rd_data_b,
    output wr_err, err_count
  );
endinterface

// File: rtl/regfile_sel32.sv
// 32-entry register bank fed by a one-hot / adjacent-pair write select.
// Optional same-edge read bypass: define REGFILE_BYPASS_EN.
module regfile_sel32 #(
  parameter int WIDTH     = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  regfile_sel32_if.slave  bus
);

  logic [WIDTH-1:0]     mem [32];
  logic [WIDTH-1:0]     rd_a_q;
  logic [WIDTH-1:0]     rd_b_q;
  logic [WIDTH-1:0]     rd_a_d;
  logic [WIDTH-1:0]     rd_b_d;
  logic                 err_q;
  logic [ERR_CNT_W-1:0] cnt_q;

  logic [31:0] sel;
  logic [31:0] low;
  logic [31:0] rest;
  logic [31:0] we_lo;
  logic [31:0] we_hi;
  logic        single;
  logic        pair;
  logic        illegal;

  assign sel = bus.wr_sel;

  // low isolates the lowest set bit; a pair leaves exactly low<<1 behind
  assign low    = sel & (~sel + 32'd1);
  assign rest   = sel ^ low;
  assign single = (sel != '0) && (rest == '0);
  assign pair   = (rest != '0) && (rest == (low << 1));

  always_comb begin
    we_lo   = '0;
    we_hi   = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (sel == '0): ;
      single: we_lo = low;
      pair: begin
        we_lo = low;
        we_hi = low << 1;
      end
      default: illegal = 1'b1;
    endcase
  end

  always_comb begin
    rd_a_d = mem[bus.rd_addr_a];
    rd_b_d = mem[bus.rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (we_lo[bus.rd_addr_a]) rd_a_d = bus.wr_data_lo;
    else if (we_hi[bus.rd_addr_a]) rd_a_d = bus.wr_data_hi;
    if (we_lo[bus.rd_addr_b]) rd_b_d = bus.wr_data_lo;
    else if (we_hi[bus.rd_addr_b]) rd_b_d = bus.wr_data_hi;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (we_lo[i]) mem[i] <= bus.wr_data_lo;
        else if (we_hi[i]) mem[i] <= bus.wr_data_hi;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
      err_q  <= illegal;
      if (illegal && (cnt_q != '1)) cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.rd_data_a = rd_a_q;
  assign bus.rd_data_b = rd_b_q;
  assign bus.wr_err    = err_q;
  assign bus.err_count = cnt_q;

endmodule

// File: tb/tb_regfile_sel32.sv
// Directed bench for regfile_sel32: writes, pairs, errors,
// saturation, same-edge read and asynchronous reset.
module tb_regfile_sel32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  regfile_sel32_if #(.WIDTH(32), .ERR_CNT_W(8)) bus ();
  regfile_sel32_if #(.WIDTH(32), .ERR_CNT_W(2)) bus2 ();

  regfile_sel32 #(.WIDTH(32), .ERR_CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  regfile_sel32 #(.WIDTH(32), .ERR_CNT_W(2)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] sel,
                    input logic [31:0] lo,
                    input logic [31:0] hi);
    bus.wr_sel     = sel;
    bus.wr_data_lo = lo;
    bus.wr_data_hi = hi;
    tick();
    bus.wr_sel = '0;
  endtask

  task automatic rd(input logic [4:0] a,
                    input logic [4:0] b,
                    input logic [31:0] ea,
                    input logic [31:0] eb,
                    input string tag);
    bus.wr_sel    = '0;
    bus.rd_addr_a = a;
    bus.rd_addr_b = b;
    tick();
    check({tag, "_a"}, bus.rd_data_a, ea);
    check({tag, "_b"}, bus.rd_data_b, eb);
  endtask

  logic [31:0] same_exp;

  initial begin
    bus.wr_sel = '0;
    bus.wr_data_lo = '0;
    bus.wr_data_hi = '0;
    bus.rd_addr_a = '0;
    bus.rd_addr_b = '0;
    bus2.wr_sel = '0;
    bus2.wr_data_lo = '0;
    bus2.wr_data_hi = '0;
    bus2.rd_addr_a = '0;
    bus2.rd_addr_b = '0;

    tick();
    tick();
    reset = 1'b0;
    check("rst_err", {31'd0, bus.wr_err}, 32'd0);
    check("rst_cnt", {24'd0, bus.err_count}, 32'd0);
    check("rst_cnt2", {30'd0, bus2.err_count}, 32'd0);
    for (int i = 0; i < 32; i++)
      rd(5'(i), 5'(31 - i), 32'd0, 32'd0, "rst_rd");

    wr(32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
    rd(5'd4, 5'd5, 32'hDEAD_BEEF, 32'd0, "single4");
    rd(5'd3, 5'd0, 32'd0, 32'd0, "others");

    wr(32'h0000_0C00, 32'h1111_1111, 32'h2222_2222);
    rd(5'd10, 5'd11, 32'h1111_1111, 32'h2222_2222, "pair10");
    rd(5'd9, 5'd12, 32'd0, 32'd0, "pair_nb");

    wr(32'h8000_0000, 32'h5, 32'h9);
    check("bit31_err", {31'd0, bus.wr_err}, 32'd0);
    rd(5'd31, 5'd30, 32'h5, 32'd0, "bit31");

    bus.wr_data_lo = 32'hFFFF_FFFF;
    bus.wr_data_hi = 32'hFFFF_FFFF;
    bus.wr_sel = 32'h0000_0005;
    tick();
    check("ill1_err", {31'd0, bus.wr_err}, 32'd1);
    check("ill1_cnt", {24'd0, bus.err_count}, 32'd1);
    bus.wr_sel = 32'h0000_0007;
    tick();
    check("ill2_err", {31'd0, bus.wr_err}, 32'd1);
    check("ill2_cnt", {24'd0, bus.err_count}, 32'd2);
    bus.wr_sel = '0;
    tick();
    check("ill_done", {31'd0, bus.wr_err}, 32'd0);
    check("ill_cnt", {24'd0, bus.err_count}, 32'd2);
    rd(5'd0, 5'd1, 32'd0, 32'd0, "ill_rd01");
    rd(5'd2, 5'd4, 32'd0, 32'hDEAD_BEEF, "ill_rd24");

    bus.wr_sel = 32'h8000_0001;
    tick();
    bus.wr_sel = '0;
    check("wrap_err", {31'd0, bus.wr_err}, 32'd1);
    check("wrap_cnt", {24'd0, bus.err_count}, 32'd3);
    rd(5'd0, 5'd31, 32'd0, 32'h5, "wrap_rd");

    for (int i = 0; i < 6; i++) begin
      bus2.wr_sel = (i % 2 == 0) ? 32'h0000_0005 : 32'h0000_0007;
      tick();
      check("sat_err", {31'd0, bus2.wr_err}, 32'd1);
    end
    bus2.wr_sel = '0;
    check("sat_cnt", {30'd0, bus2.err_count}, 32'd3);

`ifdef REGFILE_BYPASS_EN
    same_exp = 32'hA5A5_A5A5;
`else
    same_exp = 32'd0;
`endif
    bus.rd_addr_a = 5'd7;
    bus.rd_addr_b = 5'd7;
    wr(32'h0000_0080, 32'hA5A5_A5A5, 32'h0);
    check("same_a", bus.rd_data_a, same_exp);
    check("same_b", bus.rd_data_b, same_exp);
    rd(5'd7, 5'd7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, "after7");

    wr(32'h0000_0018, 32'h3333_3333, 32'h4444_4444);
    rd(5'd3, 5'd4, 32'h3333_3333, 32'h4444_4444, "pair34");
    bus.wr_sel = 32'h0000_0001;
    bus.wr_data_lo = 32'h7777_7777;
    #2;
    reset = 1'b1;
    #1;
    check("arst_a", bus.rd_data_a, 32'd0);
    check("arst_b", bus.rd_data_b, 32'd0);
    check("arst_cnt", {24'd0, bus.err_count}, 32'd0);
    tick();
    bus.wr_sel = '0;
    reset = 1'b0;
    rd(5'd3, 5'd4, 32'd0, 32'd0, "post34");
    rd(5'd0, 5'd7, 32'd0, 32'd0, "post07");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
